sparse_row_sequencer: RTL and testbench

//  Parametrised row sequencer for the sparse convolution PE datapath.

---
 rtl/sparse_pe_pkg.sv | 22 ++
 rtl/out_addr_gen.sv | 42 ++++
 rtl/sparse_row_sequencer.sv | 178 +++++++++++++++++
 tb/tb_sparse_row_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pe_pkg.sv
// Shared definitions for the sparse convolution PE datapath: sequencer state codes
// and field extraction for packed {index,value} RAM words.
`ifndef SPARSE_PE_PKG_SV
`define SPARSE_PE_PKG_SV

`define SPR_IDX(word, iw, vw) word[(iw)+(vw)-1:(vw)]
`define SPR_VAL(word, vw) word[(vw)-1:0]

package sparse_pe_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_HDR_RD   = 3'd1;
    localparam state_t S_HDR_WAIT = 3'd2;
    localparam state_t S_STREAM   = 3'd3;
    localparam state_t S_FLUSH    = 3'd4;
    localparam state_t S_DONE     = 3'd5;

endpackage

`endif

// File: rtl/out_addr_gen.sv
// Output-RAM write address: advances by the PE pop count while streaming,
// or by the full lane count K when a row is flushed. Wraps modulo 2^OUT_AW.
module out_addr_gen
    import sparse_pe_pkg::*;
#(
    parameter int K      = 5,
    parameter int OUT_AW = 5,
    parameter int POP_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pop_en,
    input  logic              flush_en,
    input  logic [POP_W-1:0]  pop,
    output logic [OUT_AW-1:0] out_addr
);

    localparam logic [OUT_AW-1:0] K_STEP = OUT_AW'(K);

    logic [OUT_AW-1:0] addr_q;
    logic [OUT_AW-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (flush_en) begin
            addr_d = addr_q + K_STEP;
        end else if (pop_en) begin
            addr_d = addr_q + OUT_AW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign out_addr = addr_q;

endmodule

// File: rtl/sparse_row_sequencer.sv
// Row sequencer: fetches compressed rows (header + nonzeros) from the input RAM,
// streams them to the PE one slot per cycle, and closes each row with a flush slot.
module sparse_row_sequencer
    import sparse_pe_pkg::*;
#(
    parameter int K       = 5,
    parameter int IDX_W   = 8,
    parameter int VAL_W   = 8,
    parameter int ROW_LEN = 28,
    parameter int IN_AW   = 5,
    parameter int OUT_AW  = 5,
    parameter int POP_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             num_rows,
    input  logic                   stall,
    output logic                   in_rd_en,
    output logic [IN_AW-1:0]       in_addr,
    input  logic [IDX_W+VAL_W-1:0] in_data,
    output logic                   pe_valid,
    output logic [IDX_W-1:0]       pe_index,
    output logic [VAL_W-1:0]       pe_value,
    output logic [IDX_W-1:0]       pe_cnt,
    input  logic [POP_W-1:0]       pe_pop,
    output logic [OUT_AW-1:0]      out_addr,
    output logic [POP_W-1:0]       out_pop,
    output logic                   row_fini,
    output logic                   row_err,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             dbg_state
);

    localparam logic [IDX_W-1:0] ROW_LEN_L = IDX_W'(ROW_LEN);
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IN_AW-1:0] in_addr_q, in_addr_d;
    logic [IDX_W-1:0] nnz_q, nnz_d;
    logic [IDX_W-1:0] slot_q, slot_d;
    logic [7:0]       rows_q, rows_d;
    logic [7:0]       num_rows_q, num_rows_d;
    logic             row_err_q, row_err_d;

    logic [IDX_W-1:0] hdr_cnt;
    logic [IDX_W-1:0] hdr_nnz;
    logic             rd_fire;
    logic             in_stream;
    logic             in_flush;
    logic             pop_en;
    logic             flush_en;

    always_comb begin
        hdr_cnt = `SPR_IDX(in_data, IDX_W, VAL_W);
        hdr_nnz = (hdr_cnt > ROW_LEN_L) ? ROW_LEN_L : hdr_cnt;
    end

    // Reads are issued in the same cycle the previous word is presented, so a
    // stalled slot keeps its data because the RAM holds its last output.
    always_comb begin
        state_d    = state_q;
        in_addr_d  = in_addr_q;
        nnz_d      = nnz_q;
        slot_d     = slot_q;
        rows_d     = rows_q;
        num_rows_d = num_rows_q;
        row_err_d  = row_err_q;
        rd_fire    = 1'b0;
        if (!stall) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_rows_d = num_rows;
                        rows_d     = '0;
                        row_err_d  = 1'b0;
                        state_d    = (num_rows == 8'd0) ? S_DONE : S_HDR_RD;
                    end
                end
                S_HDR_RD: begin
                    rd_fire = 1'b1;
                    state_d = S_HDR_WAIT;
                end
                S_HDR_WAIT: begin
                    nnz_d  = hdr_nnz;
                    slot_d = ONE;
                    if (hdr_cnt > ROW_LEN_L) begin
                        row_err_d = 1'b1;
                    end
                    if (hdr_nnz == '0) begin
                        state_d = S_FLUSH;
                    end else begin
                        rd_fire = 1'b1;
                        state_d = S_STREAM;
                    end
                end
                S_STREAM: begin
                    slot_d = slot_q + ONE;
                    if (slot_q == nnz_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        rd_fire = 1'b1;
                    end
                end
                S_FLUSH: begin
                    rows_d  = rows_q + 8'd1;
                    state_d = (rows_d == num_rows_q) ? S_DONE : S_HDR_RD;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        if (rd_fire) begin
            in_addr_d = in_addr_q + IN_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_addr_q  <= '0;
            nnz_q      <= '0;
            slot_q     <= '0;
            rows_q     <= '0;
            num_rows_q <= '0;
            row_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_addr_q  <= in_addr_d;
            nnz_q      <= nnz_d;
            slot_q     <= slot_d;
            rows_q     <= rows_d;
            num_rows_q <= num_rows_d;
            row_err_q  <= row_err_d;
        end
    end

    assign in_stream = (state_q == S_STREAM);
    assign in_flush  = (state_q == S_FLUSH);

    // The first slot of a row carries no PE results yet, so it never writes.
    assign pop_en   = !stall && in_stream && (slot_q != ONE);
    assign flush_en = !stall && in_flush;

    always_comb begin
        in_rd_en  = rd_fire;
        in_addr   = in_addr_q;
        pe_valid  = !stall && (in_stream || in_flush);
        pe_index  = in_stream ? `SPR_IDX(in_data, IDX_W, VAL_W) : '0;
        pe_value  = in_stream ? `SPR_VAL(in_data, VAL_W) : '0;
        pe_cnt    = (in_stream || in_flush) ? slot_q : '0;
        out_pop   = (pop_en || flush_en) ? pe_pop : '0;
        row_fini  = flush_en;
        row_err   = row_err_q;
        busy      = (state_q != S_IDLE);
        done      = !stall && (state_q == S_DONE);
        dbg_state = state_q;
    end

    out_addr_gen #(
        .K      (K),
        .OUT_AW (OUT_AW),
        .POP_W  (POP_W)
    ) u_out_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .pop_en   (pop_en),
        .flush_en (flush_en),
        .pop      (pe_pop),
        .out_addr (out_addr)
    );

endmodule

// File: tb/tb_sparse_row_sequencer.sv
// Directed bench for sparse_row_sequencer: a behavioural RAM, a frame-level
// expectation model (read addresses, slots, output address) and literal checks.
`timescale 1ns/1ps
module tb_sparse_row_sequencer;

    localparam int K       = 5;
    localparam int ROW_LEN = 28;
    localparam int CYC_MAX = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_rows = 8'd0;
    logic        stall = 1'b0;
    logic        in_rd_en;
    logic [4:0]  in_addr;
    logic [15:0] in_data = 16'h0;
    logic        pe_valid;
    logic [7:0]  pe_index;
    logic [7:0]  pe_value;
    logic [7:0]  pe_cnt;
    logic [2:0]  pe_pop = 3'd1;
    logic [4:0]  out_addr;
    logic [2:0]  out_pop;
    logic        row_fini;
    logic        row_err;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    sparse_row_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .stall(stall),
        .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data),
        .pe_valid(pe_valid), .pe_index(pe_index), .pe_value(pe_value), .pe_cnt(pe_cnt),
        .pe_pop(pe_pop), .out_addr(out_addr), .out_pop(out_pop), .row_fini(row_fini),
        .row_err(row_err), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [32];
    always @(posedge clk) begin
        if (in_rd_en) in_data <= mem[in_addr];
    end

    // Scoreboard: slot entries packed {last, fini, cnt[7:0], idx[7:0], val[7:0]}.
    logic [25:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];
    logic [7:0]  got_cnt[$];
    logic [4:0]  got_oa[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [4:0]  wp = 5'd0;
    logic [4:0]  m_oa = 5'd0;
    bit          m_busy = 1'b0;
    bit          done_due = 1'b0;
    bit          chk_en = 1'b0;
    bit          pop_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add_hdr(input int cnt);
        mem[wp] = {8'(cnt), 8'hA5};
        exp_rd_q.push_back(wp);
        wp = wp + 5'd1;
    endtask

    task automatic add_data(input logic [7:0] idx, input logic [7:0] val, input int k);
        mem[wp] = {idx, val};
        exp_rd_q.push_back(wp);
        exp_q.push_back({1'b0, 1'b0, 8'(k), idx, val});
        wp = wp + 5'd1;
    endtask

    task automatic add_row(input int hdr, input bit last);
        int nnz;
        nnz = (hdr > ROW_LEN) ? ROW_LEN : hdr;
        add_hdr(hdr);
        for (int k = 1; k <= nnz; k++) begin
            add_data(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)), k);
        end
        exp_q.push_back({last, 1'b1, 8'(nnz + 1), 8'h00, 8'h00});
    endtask

    // Per-cycle comparison against the frame-level expectations.
    task automatic compare_cycle();
        logic [25:0] e;
        bit nb;
        if (stall) begin
            check("stall_rd_en", in_rd_en, 0);
            check("stall_pe_valid", pe_valid, 0);
            check("stall_out_pop", out_pop, 0);
            check("stall_done", done, 0);
            check("stall_busy", busy, m_busy);
        end else begin
            check("done", done, done_due);
            nb = m_busy;
            if (done_due) nb = 1'b0;
            done_due = 1'b0;
            check("busy", busy, m_busy);
            if (!m_busy && start) begin
                nb = 1'b1;
                if (num_rows == 8'd0) done_due = 1'b1;
            end
            if (in_rd_en) begin
                if (exp_rd_q.size() == 0) check("read_extra", in_rd_en, 0);
                else check("read_addr", in_addr, exp_rd_q.pop_front());
            end
            if (pe_valid) begin
                got_cnt.push_back(pe_cnt);
                got_oa.push_back(out_addr);
                if (exp_q.size() == 0) begin
                    check("slot_extra", pe_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pe_index", pe_index, e[15:8]);
                    check("pe_value", pe_value, e[7:0]);
                    check("pe_cnt", pe_cnt, e[23:16]);
                    check("row_fini", row_fini, e[24]);
                    check("out_addr", out_addr, m_oa);
                    if (e[24]) begin
                        check("flush_pop", out_pop, pe_pop);
                        m_oa = m_oa + 5'(K);
                        if (e[25]) done_due = 1'b1;
                    end else if (e[23:16] == 8'd1) begin
                        check("first_slot_pop", out_pop, 0);
                    end else begin
                        check("stream_pop", out_pop, pe_pop);
                        m_oa = m_oa + 5'(pe_pop);
                    end
                end
            end else begin
                check("idle_pop", out_pop, 0);
                check("idle_fini", row_fini, 0);
                check("idle_oa", out_addr, m_oa);
            end
            m_busy = nb;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) compare_cycle();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 pe_pop = pop_rand ? 3'($urandom_range(0, 5)) : 3'd1;
        end
    end

    task automatic run_frame(input logic [7:0] n, output int cyc, output int first_v);
        bit seen;
        seen = 1'b0;
        num_rows = n;
        got_cnt.delete();
        got_oa.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        first_v = 0;
        while (!seen && cyc < CYC_MAX) begin
            @(negedge clk);
            cyc++;
            if (pe_valid && first_v == 0) first_v = cyc;
            if (done && !stall) seen = 1'b1;
        end
        if (!seen) check("frame_timeout", done, 1);
        check("slots_left", exp_q.size(), 0);
        check("reads_left", exp_rd_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pe_valid"}, pe_valid, 0);
        check({tag, "_in_rd_en"}, in_rd_en, 0);
        check({tag, "_in_addr"}, in_addr, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_out_pop"}, out_pop, 0);
        check({tag, "_pe_cnt"}, pe_cnt, 0);
        check({tag, "_pe_index"}, pe_index, 0);
        check({tag, "_row_fini"}, row_fini, 0);
        check({tag, "_row_err"}, row_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_dbg_state"}, dbg_state, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, fv;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        chk_en = 1'b1;

        // One row, nnz=3, constant pop of 1
        add_hdr(3);
        add_data(8'd2, 8'd7, 1);
        add_data(8'd9, 8'd1, 2);
        add_data(8'd20, 8'd4, 3);
        exp_q.push_back({1'b1, 1'b1, 8'd4, 8'd0, 8'd0});
        run_frame(8'd1, cyc, fv);
        check("t1_first_valid", fv, 3);
        check("t1_cycles", cyc, 7);
        check("t1_nslots", got_cnt.size(), 4);
        for (int i = 0; i < 4; i++) check("t1_cnt", got_cnt[i], i + 1);
        check("t1_oa0", got_oa[0], 0);
        check("t1_oa1", got_oa[1], 0);
        check("t1_oa2", got_oa[2], 1);
        check("t1_oa3", got_oa[3], 2);
        check("t1_oa_end", out_addr, 7);

        // Empty row: header, wait, flush only
        add_row(0, 1'b1);
        run_frame(8'd1, cyc, fv);
        check("t2_cycles", cyc, 4);
        check("t2_first_valid", fv, 3);
        check("t2_cnt", got_cnt[0], 1);
        check("t2_oa_end", out_addr, 12);

        // Header count above ROW_LEN is clamped and flagged
        add_row(40, 1'b1);
        run_frame(8'd1, cyc, fv);
        check("t3_cycles", cyc, 32);
        check("t3_row_err", row_err, 1);
        check("t3_last_cnt", got_cnt[28], 29);
        check("t3_oa_end", out_addr, 12);

        // Three-cycle stall at slot 2; row_err cleared by this start
        add_row(3, 1'b1);
        fork
            run_frame(8'd1, cyc, fv);
            begin
                int w;
                w = 0;
                do begin @(negedge clk); w++; end while (!(pe_valid && pe_cnt == 8'd1) && w < 50);
                @(posedge clk); #1 stall = 1'b1;
                repeat (3) @(posedge clk);
                #1 stall = 1'b0;
            end
        join
        check("t4_cycles", cyc, 10);
        check("t4_row_err_cleared", row_err, 0);
        check("t4_nslots", got_cnt.size(), 4);
        check("t4_cnt_after_stall", got_cnt[1], 2);
        check("t4_oa_end", out_addr, 19);

        // Output address wraps on flush: 30 + K -> 3
        add_row(12, 1'b1);
        run_frame(8'd1, cyc, fv);
        check("t5_cycles", cyc, 16);
        check("t5_oa_flush", got_oa[12], 30);
        check("t5_oa_wrap", out_addr, 3);

        // Multi-row frame with varying pops and an ignored start while busy
        pop_rand = 1'b1;
        add_row(2, 1'b0);
        add_row(0, 1'b0);
        add_row(4, 1'b1);
        fork
            run_frame(8'd3, cyc, fv);
            begin
                repeat (6) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        pop_rand = 1'b0;
        check("t6_cycles", cyc, 16);
        check("t6_nslots", got_cnt.size(), 9);

        // Zero-row frame finishes immediately
        run_frame(8'd0, cyc, fv);
        check("t7_cycles", cyc, 1);
        check("t7_first_valid", fv, 0);
        check("t7_in_addr", in_addr, wp);

        // Reset during the second row's stream; a new frame afterwards still works
        add_row(2, 1'b0);
        add_row(3, 1'b1);
        num_rows = 8'd2;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("t8_row2_valid", pe_valid, 1);
        check("t8_row2_cnt", pe_cnt, 1);
        #1 chk_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        exp_rd_q.delete();
        m_oa = 5'd0;
        m_busy = 1'b0;
        done_due = 1'b0;
        wp = 5'd0;
        chk_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t8_no_done", done, 0);
        end
        add_row(1, 1'b1);
        run_frame(8'd1, cyc, fv);
        check("t8_cycles", cyc, 5);
        check("t8_oa_end", out_addr, 5);
        check("t8_in_addr", in_addr, 2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
